// File: rtl/vec_fp_unpacker.sv
// vec_fp_unpacker
// Front-end operand decoder for the vector FP multiplier. A start captures two
// packed vectors of single-precision operands. One lane per cycle is then
// unpacked into sign, hidden-bit mantissas, biased exponent sum and
// zero/special/underflow flags. A done pulse marks the end of each vector.

module vec_fp_unpacker #(
    parameter int LANES = 4,
    parameter int IDXW  = $clog2(LANES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [32*LANES-1:0]   vec_a,
    input  logic [32*LANES-1:0]   vec_b,
    input  logic                  hold,
    output logic                  ready,
    output logic                  out_valid,
    output logic [IDXW-1:0]       lane_idx,
    output logic                  sign_out,
    output logic [23:0]           mant_a,
    output logic [23:0]           mant_b,
    output logic [8:0]            exp_sum,
    output logic                  zero,
    output logic                  special,
    output logic                  underflow,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        UNPACK,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic [32*LANES-1:0]   r_vecA;
    logic [32*LANES-1:0]   r_vecB;
    logic [IDXW-1:0]       r_idx;

    logic [31:0]           w_lanesA [LANES];
    logic [31:0]           w_lanesB [LANES];
    logic [31:0]           w_laneA;
    logic [31:0]           w_laneB;

    logic [7:0]            w_expA;
    logic [7:0]            w_expB;
    logic                  w_zeroA;
    logic                  w_zeroB;
    logic                  w_specA;
    logic                  w_specB;
    logic [23:0]           w_mantA;
    logic [23:0]           w_mantB;
    logic [9:0]            w_sum;
    logic                  w_zero;
    logic                  w_special;
    logic                  w_underflow;
    logic [8:0]            w_expSum;

    logic                  w_accept;
    logic                  w_advance;
    logic                  w_lastLane;

    // Split the captured vectors into addressable 32-bit lanes.
    for (genvar g = 0; g < LANES; g++) begin : gLanes
        assign w_lanesA[g] = r_vecA[32*g +: 32];
        assign w_lanesB[g] = r_vecB[32*g +: 32];
    end

    assign w_laneA    = w_lanesA[r_idx];
    assign w_laneB    = w_lanesB[r_idx];

    assign ready      = (r_state == IDLE);
    assign w_accept   = ready && start;
    assign w_advance  = (r_state == UNPACK) && !hold;
    assign w_lastLane = (r_idx == IDXW'(LANES - 1));

    // Decode the selected lane: classify each operand, then form the biased exponent sum.
    always_comb begin
        w_expA      = w_laneA[30:23];
        w_expB      = w_laneB[30:23];
        w_zeroA     = (w_expA == 8'd0);
        w_zeroB     = (w_expB == 8'd0);
        w_specA     = (w_expA == 8'hFF);
        w_specB     = (w_expB == 8'hFF);
        w_mantA     = w_zeroA ? 24'd0 : {1'b1, w_laneA[22:0]};
        w_mantB     = w_zeroB ? 24'd0 : {1'b1, w_laneB[22:0]};
        w_zero      = w_zeroA || w_zeroB;
        w_special   = w_specA || w_specB;
        w_sum       = {2'b00, w_expA} + {2'b00, w_expB};
        w_underflow = 1'b0;
        w_expSum    = 9'd0;
        if (!w_zero && !w_special) begin
            if (w_sum < 10'd127) begin
                w_underflow = 1'b1;
            end else begin
                w_expSum = w_sum[8:0] - 9'd127;
            end
        end
    end

    // State register; reset aborts any vector in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: one UNPACK pass over all lanes, then a single DONE cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = UNPACK;
                end
            end
            UNPACK: begin
                if (!hold && w_lastLane) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Operand capture, lane counter and registered lane outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vecA    <= '0;
            r_vecB    <= '0;
            r_idx     <= '0;
            out_valid <= 1'b0;
            lane_idx  <= '0;
            sign_out  <= 1'b0;
            mant_a    <= 24'd0;
            mant_b    <= 24'd0;
            exp_sum   <= 9'd0;
            zero      <= 1'b0;
            special   <= 1'b0;
            underflow <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= w_advance;
            done      <= (r_state == DONE);
            if (w_accept) begin
                r_vecA <= vec_a;
                r_vecB <= vec_b;
                r_idx  <= '0;
            end
            if (w_advance) begin
                lane_idx  <= r_idx;
                sign_out  <= w_laneA[31] ^ w_laneB[31];
                mant_a    <= w_mantA;
                mant_b    <= w_mantB;
                exp_sum   <= w_expSum;
                zero      <= w_zero;
                special   <= w_special;
                underflow <= w_underflow;
                if (w_lastLane) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_fp_unpacker.sv
// Testbench for vec_fp_unpacker: a lane-level reference model checked every
// cycle, plus literal per-lane tables and latency checks for directed vectors.

module tb_vec_fp_unpacker;

    localparam int LANES = 4;
    localparam int IDXW  = 2;

    typedef struct packed {
        logic        sign;
        logic [23:0] mantA;
        logic [23:0] mantB;
        logic [8:0]  expSum;
        logic        zero;
        logic        special;
        logic        under;
    } lane_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                hold = 1'b0;
    logic [32*LANES-1:0] vec_a = '0;
    logic [32*LANES-1:0] vec_b = '0;
    logic                ready;
    logic                out_valid;
    logic [IDXW-1:0]     lane_idx;
    logic                sign_out;
    logic [23:0]         mant_a;
    logic [23:0]         mant_b;
    logic [8:0]          exp_sum;
    logic                zero;
    logic                special;
    logic                underflow;
    logic                done;

    int checkCount = 0;
    int errorCount = 0;
    bit checkEn = 1'b0;

    localparam logic [127:0] V1A = {32'h00000001, 32'h00800000, 32'h7F7FFFFF, 32'h3FC00000};
    localparam logic [127:0] V1B = {32'h3F800000, 32'h00800000, 32'h7F7FFFFF, 32'h40000000};
    localparam logic [127:0] V2A = {32'hC0400000, 32'h80000000, 32'h7FC00000, 32'h7F800000};
    localparam logic [127:0] V2B = {32'h40800000, 32'h3F800000, 32'h00000000, 32'hBF800000};

    lane_t litV1 [LANES];
    lane_t litV2 [LANES];

    vec_fp_unpacker #(.LANES(LANES)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .hold      (hold),
        .ready     (ready),
        .out_valid (out_valid),
        .lane_idx  (lane_idx),
        .sign_out  (sign_out),
        .mant_a    (mant_a),
        .mant_b    (mant_b),
        .exp_sum   (exp_sum),
        .zero      (zero),
        .special   (special),
        .underflow (underflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand decode from the IEEE-754 field rules, using plain integer arithmetic.
    function automatic lane_t decode(input logic [31:0] a, input logic [31:0] b);
        lane_t r;
        int ea;
        int eb;
        int s;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        r = '0;
        r.sign    = a[31] ^ b[31];
        r.zero    = (ea == 0) || (eb == 0);
        r.special = (ea == 255) || (eb == 255);
        r.mantA   = (ea == 0) ? 24'h0 : {1'b1, a[22:0]};
        r.mantB   = (eb == 0) ? 24'h0 : {1'b1, b[22:0]};
        if (!r.zero && !r.special) begin
            s = ea + eb - 127;
            if (s < 0) r.under = 1'b1;
            else       r.expSum = 9'(s);
        end
        return r;
    endfunction

    // Reference model: a vector in flight emits one lane per unstalled edge, then one done edge.
    logic [127:0] mA = '0;
    logic [127:0] mB = '0;
    bit           mBusy = 1'b0;
    bit           mDonePend = 1'b0;
    int           mNext = 0;
    bit           eValid = 1'b0;
    bit           eDone = 1'b0;
    int           eIdx = 0;
    lane_t        eLane = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mBusy     <= 1'b0;
            mDonePend <= 1'b0;
            mNext     <= 0;
            eValid    <= 1'b0;
            eDone     <= 1'b0;
            eIdx      <= 0;
            eLane     <= '0;
        end else begin
            eValid <= 1'b0;
            eDone  <= 1'b0;
            if (mDonePend) begin
                eDone     <= 1'b1;
                mDonePend <= 1'b0;
            end else if (mBusy) begin
                if (!hold) begin
                    eLane  <= decode(mA[32*mNext +: 32], mB[32*mNext +: 32]);
                    eIdx   <= mNext;
                    eValid <= 1'b1;
                    if (mNext == LANES - 1) begin
                        mBusy     <= 1'b0;
                        mDonePend <= 1'b1;
                    end else begin
                        mNext <= mNext + 1;
                    end
                end
            end else if (start) begin
                mA    <= vec_a;
                mB    <= vec_b;
                mNext <= 0;
                mBusy <= 1'b1;
            end
        end
    end

    task automatic checkOutput();
        checkVal("ready",     32'(ready),     32'(!mBusy && !mDonePend));
        checkVal("out_valid", 32'(out_valid), 32'(eValid));
        checkVal("done",      32'(done),      32'(eDone));
        checkVal("lane_idx",  32'(lane_idx),  32'(eIdx));
        checkVal("sign_out",  32'(sign_out),  32'(eLane.sign));
        checkVal("mant_a",    32'(mant_a),    32'(eLane.mantA));
        checkVal("mant_b",    32'(mant_b),    32'(eLane.mantB));
        checkVal("exp_sum",   32'(exp_sum),   32'(eLane.expSum));
        checkVal("zero",      32'(zero),      32'(eLane.zero));
        checkVal("special",   32'(special),   32'(eLane.special));
        checkVal("underflow", 32'(underflow), 32'(eLane.under));
    endtask

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    task automatic checkLane(input int which);
        lane_t l;
        l = (which == 2) ? litV2[lane_idx] : litV1[lane_idx];
        checkVal("lit_sign",      32'(sign_out),  32'(l.sign));
        checkVal("lit_mant_a",    32'(mant_a),    32'(l.mantA));
        checkVal("lit_mant_b",    32'(mant_b),    32'(l.mantB));
        checkVal("lit_exp_sum",   32'(exp_sum),   32'(l.expSum));
        checkVal("lit_zero",      32'(zero),      32'(l.zero));
        checkVal("lit_special",   32'(special),   32'(l.special));
        checkVal("lit_underflow", 32'(underflow), 32'(l.under));
    endtask

    task automatic applyStimulus(input logic [127:0] a, input logic [127:0] b, input int which,
                                 input bit useHold, input int expDoneK);
        int k;
        int doneK;
        int validCount;
        int holdLeft;
        int firstIdx;
        k = 0; doneK = -1; validCount = 0; holdLeft = 0; firstIdx = -1;
        vec_a = a;
        vec_b = b;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        while (k < 40 && doneK < 0) begin
            @(negedge clk);
            #1;
            k++;
            if (holdLeft > 0) begin
                holdLeft--;
                if (holdLeft == 2) start = 1'b0;
                if (holdLeft == 0) hold = 1'b0;
            end
            if (out_valid) begin
                validCount++;
                if (firstIdx < 0) firstIdx = int'(lane_idx);
                checkLane(which);
                if (useHold && lane_idx == 2'd1) begin
                    hold     = 1'b1;
                    holdLeft = 3;
                    start    = 1'b1;
                    vec_a    = ~a;
                    vec_b    = ~b;
                end
            end
            if (done) doneK = k;
        end
        checkVal("done_latency", 32'(doneK), 32'(expDoneK));
        checkVal("valid_count", 32'(validCount), 32'(LANES));
        checkVal("first_lane", 32'(firstIdx), 32'd0);
    endtask

    initial begin
        int k;
        int found;
        int doneSeen;
        int lane3K;
        int doneK;
        int secondK;

        litV1[0] = '{1'b0, 24'hC00000, 24'h800000, 9'h080, 1'b0, 1'b0, 1'b0};
        litV1[1] = '{1'b0, 24'hFFFFFF, 24'hFFFFFF, 9'h17D, 1'b0, 1'b0, 1'b0};
        litV1[2] = '{1'b0, 24'h800000, 24'h800000, 9'h000, 1'b0, 1'b0, 1'b1};
        litV1[3] = '{1'b0, 24'h000000, 24'h800000, 9'h000, 1'b1, 1'b0, 1'b0};
        litV2[0] = '{1'b1, 24'h800000, 24'h800000, 9'h000, 1'b0, 1'b1, 1'b0};
        litV2[1] = '{1'b0, 24'hC00000, 24'h000000, 9'h000, 1'b1, 1'b1, 1'b0};
        litV2[2] = '{1'b1, 24'h000000, 24'h800000, 9'h000, 1'b1, 1'b0, 1'b0};
        litV2[3] = '{1'b1, 24'hC00000, 24'h800000, 9'h082, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        checkEn = 1'b1;
        @(negedge clk);
        #1;
        checkVal("rst_ready",     32'(ready),     32'd1);
        checkVal("rst_out_valid", 32'(out_valid), 32'd0);
        checkVal("rst_done",      32'(done),      32'd0);
        checkVal("rst_exp_sum",   32'(exp_sum),   32'd0);

        hold = 1'b1;
        repeat (2) @(posedge clk);
        #2 hold = 1'b0;

        $display("[TB] vector 1, no stalls");
        applyStimulus(V1A, V1B, 1, 1'b0, 6);

        $display("[TB] vector 2, three-cycle hold after lane 1, start pulse while busy");
        applyStimulus(V2A, V2B, 2, 1'b1, 9);

        $display("[TB] reset abort at lane 2");
        vec_a = V1A;
        vec_b = V1B;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        k = 0; found = 0;
        while (k < 20 && found == 0) begin
            @(negedge clk);
            #1;
            k++;
            if (out_valid && lane_idx == 2'd2) found = 1;
        end
        checkVal("reach_lane2", 32'(found), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkVal("abort_out_valid", 32'(out_valid), 32'd0);
        checkVal("abort_lane_idx",  32'(lane_idx),  32'd0);
        checkVal("abort_mant_a",    32'(mant_a),    32'd0);
        checkVal("abort_mant_b",    32'(mant_b),    32'd0);
        checkVal("abort_underflow", 32'(underflow), 32'd0);
        checkVal("abort_done",      32'(done),      32'd0);
        checkVal("abort_ready",     32'(ready),     32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (done) doneSeen++;
        end
        checkVal("no_done_after_abort", 32'(doneSeen), 32'd0);

        $display("[TB] new vector after abort");
        applyStimulus(V2A, V2B, 2, 1'b0, 6);

        $display("[TB] back-to-back with start held high");
        vec_a = V1A;
        vec_b = V1B;
        start = 1'b1;
        k = 0; lane3K = -1; doneK = -1; secondK = -1;
        while (k < 40 && secondK < 0) begin
            @(negedge clk);
            #1;
            k++;
            if (out_valid && lane_idx == 2'd3 && lane3K < 0) lane3K = k;
            if (done && doneK < 0) doneK = k;
            if (out_valid && lane_idx == 2'd0 && doneK >= 0) secondK = k;
        end
        start = 1'b0;
        checkVal("b2b_lane3_seen",     32'(lane3K >= 0), 32'd1);
        checkVal("b2b_done_after_l3",  32'(doneK - lane3K), 32'd1);
        checkVal("b2b_lane0_after_dn", 32'(secondK - doneK), 32'd2);
        repeat (12) @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

endmodule
